// File: rtl/data_mem_access_unit.sv
// rtl/data_mem_access_unit.sv - byte/half/word load-store front-end onto a word-wide data memory
//
// Accepts one CPU access at a time in IDLE, rejects illegal, misaligned or
// out-of-range accesses, performs loads with sign/zero extension and sub-word
// stores as read-modify-write, then pulses cpu_done for one cycle.
//
// Ports:
//   clk, reset                   clock; synchronous active-high reset
//   cpu_req/we/size/unsigned     access request and its attributes (sampled in IDLE)
//   cpu_addr, cpu_wdata          byte address; right-justified store data
//   cpu_busy, cpu_done           busy outside IDLE; one-cycle completion pulse
//   cpu_fault                    qualifies cpu_done: access rejected
//   cpu_rdata                    extended load result, held until the next load
//   fault_count                  saturating count of rejected accesses
//   mem_write, mem_address       memory write strobe; word-aligned byte address
//   mem_write_data               full word to write
//   mem_read_data                combinational read of the word at mem_address
module data_mem_access_unit #(
    parameter int ADDR_WORDS_LOG2 = 10,
    parameter int FAULT_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [1:0]                 cpu_size,
    input  logic                       cpu_unsigned,
    input  logic [31:0]                cpu_addr,
    input  logic [31:0]                cpu_wdata,
    output logic                       cpu_busy,
    output logic                       cpu_done,
    output logic                       cpu_fault,
    output logic [31:0]                cpu_rdata,
    output logic [FAULT_CNT_WIDTH-1:0] fault_count,
    output logic                       mem_write,
    output logic [31:0]                mem_address,
    output logic [31:0]                mem_write_data,
    input  logic [31:0]                mem_read_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_STORE, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 addr_lo_q, addr_lo_d;
    logic [1:0]                 size_q, size_d;
    logic                       we_q, we_d;
    logic                       uns_q, uns_d;
    logic [15:0]                wdata_q, wdata_d;
    logic                       fault_q, fault_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [FAULT_CNT_WIDTH-1:0] fault_cnt_q, fault_cnt_d;
    logic [31:0]                mem_addr_q, mem_addr_d;
    logic [31:0]                mem_wdata_q, mem_wdata_d;

    logic        req_fault;
    logic [4:0]  byte_sh, half_sh;
    logic [31:0] rd_byte_shifted, rd_half_shifted;
    logic [31:0] load_value, merged_word;

    // Checked in priority order; any hit rejects the access.
    always_comb begin
        req_fault = 1'b0;
        if (cpu_size == 2'b11) begin
            req_fault = 1'b1;
        end else if (cpu_size == 2'b01 && cpu_addr[0]) begin
            req_fault = 1'b1;
        end else if (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00) begin
            req_fault = 1'b1;
        end else if (cpu_addr[31:ADDR_WORDS_LOG2+2] != '0) begin
            req_fault = 1'b1;
        end
    end

    // Little-endian lane selection from the latched low address bits.
    always_comb begin
        byte_sh         = {addr_lo_q, 3'b000};
        half_sh         = {addr_lo_q[1], 4'b0000};
        rd_byte_shifted = mem_read_data >> byte_sh;
        rd_half_shifted = mem_read_data >> half_sh;

        case (size_q)
            2'b00:   load_value = uns_q ? {24'h0, rd_byte_shifted[7:0]}
                                        : {{24{rd_byte_shifted[7]}}, rd_byte_shifted[7:0]};
            2'b01:   load_value = uns_q ? {16'h0, rd_half_shifted[15:0]}
                                        : {{16{rd_half_shifted[15]}}, rd_half_shifted[15:0]};
            default: load_value = mem_read_data;
        endcase

        if (size_q == 2'b00) begin
            merged_word = (mem_read_data & ~(32'h0000_00FF << byte_sh))
                        | ({24'h0, wdata_q[7:0]} << byte_sh);
        end else begin
            merged_word = (mem_read_data & ~(32'h0000_FFFF << half_sh))
                        | ({16'h0, wdata_q} << half_sh);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    if (req_fault) begin
                        state_d = S_DONE;
                    end else if (cpu_we && cpu_size == 2'b10) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = we_q ? S_STORE : S_DONE;
            S_STORE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath register updates.
    always_comb begin
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        fault_cnt_d = fault_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_lo_d = cpu_addr[1:0];
                    size_d    = cpu_size;
                    we_d      = cpu_we;
                    uns_d     = cpu_unsigned;
                    wdata_d   = cpu_wdata[15:0];
                    if (req_fault) begin
                        // A rejected access leaves the memory port untouched.
                        fault_d = 1'b1;
                        if (fault_cnt_q != '1) begin
                            fault_cnt_d = fault_cnt_q + FAULT_CNT_WIDTH'(1);
                        end
                    end else begin
                        mem_addr_d  = {cpu_addr[31:2], 2'b00};
                        mem_wdata_d = cpu_wdata;
                    end
                end
            end
            S_READ: begin
                if (we_q) begin
                    mem_wdata_d = merged_word;
                end else begin
                    rdata_d = load_value;
                end
            end
            S_DONE:  fault_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_lo_q   <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            fault_cnt_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            fault_cnt_q <= fault_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Outputs. The write strobe is gated by reset so an abort in STORE never writes.
    always_comb begin
        cpu_busy       = (state_q != S_IDLE);
        cpu_done       = (state_q == S_DONE);
        cpu_fault      = (state_q == S_DONE) && fault_q;
        mem_write      = (state_q == S_STORE) && !reset;
        cpu_rdata      = rdata_q;
        fault_count    = fault_cnt_q;
        mem_address    = mem_addr_q;
        mem_write_data = mem_wdata_q;
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb/tb_data_mem_access_unit.sv - self-checking bench for data_mem_access_unit
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_size = 2'b00;
    logic        cpu_unsigned = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_busy, cpu_done, cpu_fault, mem_write;
    logic [31:0] cpu_rdata, mem_address, mem_write_data, mem_read_data;
    logic [7:0]  fault_count;

    data_mem_access_unit #(.ADDR_WORDS_LOG2(10), .FAULT_CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
        .cpu_fault(cpu_fault), .cpu_rdata(cpu_rdata), .fault_count(fault_count),
        .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    logic [31:0] exp_mem [1024];
    int          wr_count = 0;

    assign mem_read_data = mem[mem_address[11:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address[11:2]] = mem_write_data;
            wr_count = wr_count + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs, maintained by the access model below.
    logic        chk_en = 1'b0;
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_fault = 1'b0, exp_write = 1'b0;
    logic [31:0] exp_rdata = '0, exp_waddr = '0, exp_wdata = '0;
    int          exp_count = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'h0, cpu_busy}, {31'h0, exp_busy});
            check("done", {31'h0, cpu_done}, {31'h0, exp_done});
            check("fault", {31'h0, cpu_fault}, {31'h0, exp_fault});
            check("mem_write", {31'h0, mem_write}, {31'h0, exp_write});
            check("rdata", cpu_rdata, exp_rdata);
            check("fault_count", {24'h0, fault_count}, 32'(exp_count));
            if (exp_write) begin
                check("mem_address", mem_address, exp_waddr);
                check("mem_write_data", mem_write_data, exp_wdata);
            end
        end
    end

    task automatic idle_expect();
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_fault = 1'b0;
        exp_write = 1'b0;
    endtask

    // One access from the IDLE cycle through the return to IDLE. When hold is set,
    // a conflicting store request stays asserted through every busy cycle.
    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        bit          f;
        int          lat;
        int          idx;
        int          lane;
        logic [31:0] w, val, new_word, mask;
        f = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 0)
            || (addr >= 32'h1000);
        idx = int'(addr[11:2]);
        w = exp_mem[idx];
        if (f) lat = 1;
        else if (!we || size == 2'd2) lat = 2;
        else lat = 3;
        val = w;
        new_word = wdata;
        if (size == 2'd0) begin
            lane = int'(addr[1:0]);
            val = (w >> (8 * lane)) & 32'hFF;
            if (!uns && val >= 32'h80) val = val + 32'hFFFF_FF00;
            mask = 32'hFF << (8 * lane);
            new_word = (w & ~mask) | ((wdata & 32'hFF) << (8 * lane));
        end else if (size == 2'd1) begin
            lane = int'(addr[1]);
            val = (w >> (16 * lane)) & 32'hFFFF;
            if (!uns && val >= 32'h8000) val = val + 32'hFFFF_0000;
            mask = 32'hFFFF << (16 * lane);
            new_word = (w & ~mask) | ((wdata & 32'hFFFF) << (16 * lane));
        end

        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
        cpu_addr = addr; cpu_wdata = wdata;
        idle_expect();
        @(posedge clk); #1;
        if (hold) begin
            cpu_we = 1'b1; cpu_size = 2'd2; cpu_addr = 32'h40; cpu_wdata = 32'h5555_AAAA;
        end else begin
            cpu_req = 1'b0;
        end
        if (f && exp_count < 255) exp_count++;
        for (int k = 1; k <= lat; k++) begin
            exp_busy  = 1'b1;
            exp_done  = (k == lat);
            exp_fault = f && (k == lat);
            exp_write = !f && we && (k == lat - 1);
            exp_waddr = {addr[31:2], 2'b00};
            exp_wdata = new_word;
            if (k == lat && !f && !we) exp_rdata = val;
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        idle_expect();
        if (!f && we) exp_mem[idx] = new_word;
    endtask

    int wr_before;
    int diffs;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5C3_0F96;
            exp_mem[i] = mem[i];
        end
        mem[4] = 32'h80FF_1234;
        exp_mem[4] = 32'h80FF_1234;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle_expect();
        chk_en = 1'b1;
        check("reset_mem_address", mem_address, 32'h0);
        check("reset_mem_write_data", mem_write_data, 32'h0);
        @(posedge clk); #1;

        // 1: signed and unsigned byte loads from the top lane
        access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
        check("t1_lb", cpu_rdata, 32'hFFFF_FF80);
        access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
        check("t1_lbu", cpu_rdata, 32'h0000_0080);

        // 2: half store read-modify-write, then read back
        wr_before = wr_count;
        access(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF, 1'b0);
        check("t2_one_write", 32'(wr_count - wr_before), 32'd1);
        check("t2_mem4", mem[4], 32'hBEEF_1234);
        check("t2_rdata_kept", cpu_rdata, 32'h0000_0080);
        access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
        check("t2_lhu", cpu_rdata, 32'h0000_BEEF);
        access(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
        check("t2_lh", cpu_rdata, 32'hFFFF_BEEF);
        access(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0);
        access(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b0);
        check("t2_lw", cpu_rdata, 32'hBEEF_1234);
        access(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFF_FF7E, 1'b0);
        access(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1'b0);

        // 3: word store at the last word
        access(1'b1, 2'd2, 1'b0, 32'h0FFC, 32'hDEAD_BEEF, 1'b0);
        check("t3_mem1023", mem[1023], 32'hDEAD_BEEF);
        access(1'b0, 2'd2, 1'b0, 32'h0FFC, 32'h0, 1'b0);

        // 4: misaligned and out-of-range accesses
        wr_before = wr_count;
        access(1'b0, 2'd2, 1'b0, 32'h0002, 32'h0, 1'b0);
        access(1'b1, 2'd1, 1'b0, 32'h0001, 32'h1111, 1'b0);
        access(1'b1, 2'd2, 1'b0, 32'h1000, 32'h2222_3333, 1'b0);
        check("t4_fault_count", {24'h0, fault_count}, 32'd3);
        check("t4_no_write", 32'(wr_count - wr_before), 32'd0);
        access(1'b0, 2'd3, 1'b0, 32'h0008, 32'h0, 1'b0);
        access(1'b0, 2'd0, 1'b0, 32'h8000_0000, 32'h0, 1'b0);

        // 5: request held while busy is ignored
        wr_before = wr_count;
        access(1'b1, 2'd0, 1'b0, 32'h0031, 32'h0000_00C3, 1'b1);
        check("t5_one_write", 32'(wr_count - wr_before), 32'd1);

        // 5: reset while in STORE aborts without writing
        wr_before = wr_count;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd0; cpu_unsigned = 1'b0;
        cpu_addr = 32'h0022; cpu_wdata = 32'h0000_0011;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        exp_busy = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_busy = 1'b0; exp_rdata = '0; exp_count = 0;
        check("t5_reset_no_write", 32'(wr_count - wr_before), 32'd0);
        check("t5_reset_mem8", mem[8], exp_mem[8]);
        check("t5_reset_busy", {31'h0, cpu_busy}, 32'd0);
        check("t5_reset_rdata", cpu_rdata, 32'h0);
        check("t5_reset_count", {24'h0, fault_count}, 32'd0);
        check("t5_reset_mem_address", mem_address, 32'h0);
        check("t5_reset_mem_write_data", mem_write_data, 32'h0);
        @(posedge clk); #1;
        access(1'b0, 2'd0, 1'b1, 32'h0031, 32'h0, 1'b0);
        check("t5_lbu_after", cpu_rdata, 32'h0000_00C3);

        // 6: fault counter saturation
        for (int i = 0; i < 300; i++) begin
            access(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        end
        check("t6_saturated", {24'h0, fault_count}, 32'd255);

        diffs = 0;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== exp_mem[i]) diffs++;
        end
        check("memory_sweep", 32'(diffs), 32'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
